control_mc: RTL and testbench
=============================

# control_mc

Parametrised multicycle control unit for the RV64I-subset datapath, replacing the single-latency controller. Moore-style FSM with memory wait-state counters. Adds AND/OR, BNE, LUI, JAL, and an optional illegal-instruction trap. Drives every datapath enable and mux select; outputs are fully defined in every state, with no latched values.

## Interface
- IMEM_WAIT, 1, cycles imem_read is held before the instruction is valid (≥1)
- DMEM_WAIT, 1, cycles dmem_read/dmem_write is held per access (≥1)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr  in  32  current IR contents
- alu_zero  in  1  ALU zero flag
- imem_read  out  1  instruction memory request
- ir_load  out  1  load IR and OLD_PC (OLD_PC ← PC)
- pc_write  out  1  PC load enable
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 exception vector
- reg_a_load, reg_b_load, aluout_load, mdr_load  out  1 each  register enables
- alu_src_a  out  2  0 PC, 1 A, 2 OLD_PC
- alu_src_b  out  2  0 B, 1 const 4, 2 imm, 3 imm<<1
- alu_op  out  3  0 nop, 1 add, 2 sub, 3 and, 4 or
- imm_sel  out  3  0 I, 1 S, 2 SB, 3 U, 4 UJ; decoded from instr opcode in all states
- dmem_read, dmem_write  out  1 each  data memory strobes
- reg_write  out  1  register file write
- wb_sel  out  2  0 ALUOut, 1 MDR, 2 PC, 3 imm
- epc_write, cause_write  out  1 each  trap registers; tied 0 without CTRL_EXCEPTION_EN
- state_o  out  5  current state, for debug

## Operation
- Any output not listed for a state is 0. In RESET all outputs are 0.
- RESET → FETCH.
- FETCH: imem_read=1 for IMEM_WAIT cycles (wait counter), then → FETCH_LD.
- FETCH_LD: ir_load=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=1, alu_op=1 → DECODE.
- DECODE: reg_a_load=reg_b_load=aluout_load=1, alu_src_a=2, alu_src_b=3, alu_op=1 (branch/jump target). Dispatch on instr:
  - R-type opcode 0110011, funct7 0000000 (funct3 000 add, 111 and, 110 or) or funct7 0100000 with funct3 000 (sub) → EX_R.
  - 0010011/000 (addi) → EX_I.
  - 0000011/011 (ld) or 0100011/011 (sd) → MEM_ADDR.
  - 1100011 with funct3 000 or 001 → BRANCH.
  - 0110111 → LUI.
  - 1101111 → JAL.
  - Anything else → ILLEGAL.
- EX_R: alu_src_a=1, alu_src_b=0, alu_op per funct, aluout_load=1 → WB_ALU.
- EX_I: alu_src_a=1, alu_src_b=2, alu_op=1, aluout_load=1 → WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0 → FETCH.
- MEM_ADDR: as EX_I (imm_sel S for sd) → LD_REQ or SD_REQ.
- LD_REQ: dmem_read=1 for DMEM_WAIT cycles; mdr_load=1 on the last cycle → LD_WB.
- LD_WB: reg_write=1, wb_sel=1 → FETCH.
- SD_REQ: dmem_write=1 for DMEM_WAIT cycles → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=2, pc_src=1. pc_write=alu_zero for beq, !alu_zero for bne; this is the only Mealy output. → FETCH.
- LUI: reg_write=1, wb_sel=3 → FETCH.
- JAL: reg_write=1, wb_sel=2 (link = PC, already +4), pc_write=1, pc_src=1 → FETCH.
- ILLEGAL: see Configuration.
- rd=x0 writes are still issued; the register file discards them.

## Timing
- Cycles per instruction, including fetch:
  - add/sub/and/or/addi: IMEM_WAIT+4
  - ld: IMEM_WAIT+DMEM_WAIT+4
  - sd: IMEM_WAIT+DMEM_WAIT+3
  - beq/bne/lui/jal: IMEM_WAIT+3
  - illegal: IMEM_WAIT+3
- Wait counter width is $clog2(max(IMEM_WAIT,DMEM_WAIT)+1). It clears on every state entry and never wraps; exit occurs when count == WAIT-1.
- Reset asserted mid-instruction, including during a wait: state → RESET and all outputs drop to 0 asynchronously. First FETCH starts in the cycle after reset deasserts.
- instr must be stable from FETCH_LD+1 until the instruction's return to FETCH.

## Configuration
- CTRL_EXCEPTION_EN defined: ILLEGAL asserts epc_write=1 (EPC ← OLD_PC), cause_write=1, pc_write=1, pc_src=2 → FETCH.
- Not defined: ILLEGAL asserts nothing and → FETCH, so the instruction executes as a NOP. epc_write and cause_write are constant 0.

## Structure
- Package ctrl_pkg holds:
  - state enum (RESET, FETCH, FETCH_LD, DECODE, EX_R, EX_I, WB_ALU, MEM_ADDR, LD_REQ, LD_WB, SD_REQ, BRANCH, LUI, JAL, ILLEGAL)
  - opcode/funct localparams
  - pc_src, alu_src, alu_op, imm_sel, wb_sel encodings
- One combinational sub-module, ctrl_decoder: instr → instruction class, imm_sel, alu_op for EX_R.

## Test plan
- IMEM_WAIT=1: add x3,x1,x2 (0x002081B3) after reset → states FETCH, FETCH_LD, DECODE, EX_R, WB_ALU; reg_write=1 only in cycle 5, wb_sel=0.
- IMEM_WAIT=1, DMEM_WAIT=3: ld x5,8(x1) (0x0080B283) → dmem_read high for 3 cycles, mdr_load in 3rd only, reg_write with wb_sel=1 at cycle 8.
- beq (0x00208463) with alu_zero=1 → pc_write=1, pc_src=1 in BRANCH. With alu_zero=0 → pc_write=0. bne (funct3 001) → inverse.
- jal x1,16 (0x010000EF) → in JAL state reg_write=1, wb_sel=2, pc_write=1, pc_src=1.
- Opcode 0x00000000 → with CTRL_EXCEPTION_EN: epc_write=cause_write=1, pc_src=2. Without it: all outputs 0, back to FETCH.
- Assert reset during the 2nd LD_REQ wait cycle → dmem_read=0 immediately, state_o=RESET; after release, FETCH next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, instruction-class and datapath-select encodings shared by
// the multicycle control unit (control_mc) and its decoder (ctrl_decoder).
package ctrl_pkg;

  // Controller states; the numeric value is exported on state_o for debug.
  typedef enum logic [4:0] {
    RESET    = 5'd0,
    FETCH    = 5'd1,
    FETCH_LD = 5'd2,
    DECODE   = 5'd3,
    EX_R     = 5'd4,
    EX_I     = 5'd5,
    WB_ALU   = 5'd6,
    MEM_ADDR = 5'd7,
    LD_REQ   = 5'd8,
    LD_WB    = 5'd9,
    SD_REQ   = 5'd10,
    BRANCH   = 5'd11,
    LUI      = 5'd12,
    JAL      = 5'd13,
    ILLEGAL  = 5'd14
  } state_t;

  // Instruction classes the decoder resolves, one per execution path.
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_ADDI    = 3'd1,
    CLS_LD      = 3'd2,
    CLS_SD      = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_LUI     = 3'd5,
    CLS_JAL     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instrClass_t;

  // Major opcodes of the supported subset.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 / funct7 values.
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_DOUBLE = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // pc_src
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_EXC    = 2'd2;

  // alu_src_a
  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_REG   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  // alu_src_b
  localparam logic [1:0] SRC_B_REG    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMMSH1 = 2'd3;

  // alu_op
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  // imm_sel
  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  // wb_sel
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  // Immediate format depends only on the major opcode; unknown opcodes
  // fall back to the I format so the generator always has a defined input.
  function automatic logic [2:0] immSelFor(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_SB;
      OP_LUI:    return IMM_U;
      OP_JAL:    return IMM_UJ;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: purely combinational instruction classifier. Maps the IR
// contents to an execution class, the immediate format and the ALU operation
// used by register-register instructions.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  instrClass,
  output logic [2:0]  immSel,
  output logic [2:0]  rAluOp,
  output logic        branchNe
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unusedFields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers belong to the datapath, not to control.
  assign unusedFields = ^{instr[24:15], instr[11:7]};

  assign immSel   = immSelFor(opcode);
  assign branchNe = (funct3 == F3_BNE);

  // Classify the instruction; anything not explicitly recognised is illegal.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    instrClass = CLS_ILLEGAL;
    rAluOp     = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD: begin instrClass = CLS_R; rAluOp = ALU_ADD; end
            F3_AND: begin instrClass = CLS_R; rAluOp = ALU_AND; end
            F3_OR:  begin instrClass = CLS_R; rAluOp = ALU_OR;  end
            default: instrClass = CLS_ILLEGAL;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          instrClass = CLS_R;
          rAluOp     = ALU_SUB;
        end
      end
      OP_IMM: begin
        if (funct3 == F3_ADD) instrClass = CLS_ADDI;
      end
      OP_LOAD: begin
        if (funct3 == F3_DOUBLE) instrClass = CLS_LD;
      end
      OP_STORE: begin
        if (funct3 == F3_DOUBLE) instrClass = CLS_SD;
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) instrClass = CLS_BRANCH;
      end
      OP_LUI:  instrClass = CLS_LUI;
      OP_JAL:  instrClass = CLS_JAL;
      default: instrClass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_mc.sv
// control_mc: multicycle Moore control unit for the RV64I-subset datapath.
// Memory accesses are stretched by wait-state counters (IMEM_WAIT, DMEM_WAIT).
// Optional feature macro: CTRL_EXCEPTION_EN enables the illegal-instruction
// trap (EPC/cause write and jump to the exception vector); without it an
// illegal instruction retires as a NOP and epc_write/cause_write stay 0.
module control_mc
  import ctrl_pkg::*;
#(
  parameter int IMEM_WAIT = 1,
  parameter int DMEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic        imem_read,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_a_load,
  output logic        reg_b_load,
  output logic        aluout_load,
  output logic        mdr_load,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [2:0]  imm_sel,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        epc_write,
  output logic        cause_write,
  output logic [4:0]  state_o
);

  localparam int MAX_WAIT = (IMEM_WAIT > DMEM_WAIT) ? IMEM_WAIT : DMEM_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_WAIT - 1);
  localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             imemDone;
  logic             dmemDone;

  logic [2:0]       decClass;
  logic [2:0]       decImmSel;
  logic [2:0]       decRAluOp;
  logic             decBranchNe;

  ctrl_decoder u_decoder (
    .instr      (instr),
    .instrClass (decClass),
    .immSel     (decImmSel),
    .rAluOp     (decRAluOp),
    .branchNe   (decBranchNe)
  );

  assign imemDone = (waitCnt == IMEM_LAST);
  assign dmemDone = (waitCnt == DMEM_LAST);
  assign state_o  = state;

  // State register; reset forces RESET immediately, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) state <= RESET;
    else       state <= stateNext;
  end

  // Wait counter: cleared on every state entry, saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    waitCnt <= '0;
    else if (stateNext != state)  waitCnt <= '0;
    else if (waitCnt != CNT_MAX)  waitCnt <= waitCnt + CNT_W'(1);
  end

  // Next-state logic: sequencing and instruction dispatch.
  always_comb begin
    stateNext = state;
    case (state)
      RESET:    stateNext = FETCH;
      FETCH:    if (imemDone) stateNext = FETCH_LD;
      FETCH_LD: stateNext = DECODE;
      DECODE: begin
        case (decClass)
          CLS_R:               stateNext = EX_R;
          CLS_ADDI:            stateNext = EX_I;
          CLS_LD, CLS_SD:      stateNext = MEM_ADDR;
          CLS_BRANCH:          stateNext = BRANCH;
          CLS_LUI:             stateNext = LUI;
          CLS_JAL:             stateNext = JAL;
          default:             stateNext = ILLEGAL;
        endcase
      end
      EX_R, EX_I: stateNext = WB_ALU;
      MEM_ADDR:   stateNext = (decClass == CLS_LD) ? LD_REQ : SD_REQ;
      LD_REQ:     if (dmemDone) stateNext = LD_WB;
      SD_REQ:     if (dmemDone) stateNext = FETCH;
      WB_ALU, LD_WB, BRANCH, LUI, JAL, ILLEGAL: stateNext = FETCH;
      default:    stateNext = RESET;
    endcase
  end

  // Output logic: Moore decode of the state, except pc_write in BRANCH.
  always_comb begin
    imem_read   = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_ALU;
    reg_a_load  = 1'b0;
    reg_b_load  = 1'b0;
    aluout_load = 1'b0;
    mdr_load    = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    alu_op      = ALU_NOP;
    imm_sel     = decImmSel;
    dmem_read   = 1'b0;
    dmem_write  = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = WB_ALUOUT;
    epc_write   = 1'b0;
    cause_write = 1'b0;
    case (state)
      RESET: imm_sel = IMM_I;
      FETCH: imem_read = 1'b1;
      FETCH_LD: begin
        ir_load   = 1'b1;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALU;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
      end
      DECODE: begin
        // Speculatively compute the branch/jump target into ALUOut.
        reg_a_load  = 1'b1;
        reg_b_load  = 1'b1;
        aluout_load = 1'b1;
        alu_src_a   = SRC_A_OLDPC;
        alu_src_b   = SRC_B_IMMSH1;
        alu_op      = ALU_ADD;
      end
      EX_R: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_REG;
        alu_op      = decRAluOp;
        aluout_load = 1'b1;
      end
      EX_I, MEM_ADDR: begin
        alu_src_a   = SRC_A_REG;
        alu_src_b   = SRC_B_IMM;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
      end
      WB_ALU: begin
        reg_write = 1'b1;
        wb_sel    = WB_ALUOUT;
      end
      LD_REQ: begin
        dmem_read = 1'b1;
        mdr_load  = dmemDone;
      end
      LD_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      SD_REQ: dmem_write = 1'b1;
      BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = decBranchNe ? ~alu_zero : alu_zero;
      end
      LUI: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
      end
      JAL: begin
        // PC already holds the return address after FETCH_LD.
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_ALUOUT;
      end
      ILLEGAL: begin
`ifdef CTRL_EXCEPTION_EN
        epc_write   = 1'b1;
        cause_write = 1'b1;
        pc_write    = 1'b1;
        pc_src      = PC_SRC_EXC;
`else
        // Unrecognised instructions retire as a NOP.
        imm_sel = decImmSel;
`endif
      end
      default: imm_sel = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_control_mc.sv
// tb_control_mc: self-checking bench for control_mc. A behavioural model turns
// each instruction into its expected per-cycle output list; one compare
// process checks the DUT against that list on every falling clock edge.
module tb_control_mc;
  import ctrl_pkg::*;

  localparam int IW = 1;
  localparam int DW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        imem_read, ir_load, pc_write;
  logic [1:0]  pc_src;
  logic        reg_a_load, reg_b_load, aluout_load, mdr_load;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [2:0]  alu_op, imm_sel;
  logic        dmem_read, dmem_write, reg_write;
  logic [1:0]  wb_sel;
  logic        epc_write, cause_write;
  logic [4:0]  state_o;

  control_mc #(.IMEM_WAIT(IW), .DMEM_WAIT(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .imem_read   (imem_read),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_a_load  (reg_a_load),
    .reg_b_load  (reg_b_load),
    .aluout_load (aluout_load),
    .mdr_load    (mdr_load),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .imm_sel     (imm_sel),
    .dmem_read   (dmem_read),
    .dmem_write  (dmem_write),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .epc_write   (epc_write),
    .cause_write (cause_write),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // One cycle's worth of controller outputs.
  typedef struct packed {
    logic [4:0] st;
    logic       imemRd, irLd, pcWr;
    logic [1:0] pcSrc;
    logic       aLd, bLd, aoLd, mdrLd;
    logic [1:0] srcA, srcB;
    logic [2:0] aluOp, immSel;
    logic       dRd, dWr, rWr;
    logic [1:0] wbSel;
    logic       epcWr, causeWr;
  } cyc_t;
  typedef cyc_t cycQ_t[$];

  cycQ_t expQ;
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic cyc_t sampleDut();
    cyc_t c;
    c.st = state_o;       c.imemRd = imem_read;  c.irLd = ir_load;
    c.pcWr = pc_write;    c.pcSrc = pc_src;      c.aLd = reg_a_load;
    c.bLd = reg_b_load;   c.aoLd = aluout_load;  c.mdrLd = mdr_load;
    c.srcA = alu_src_a;   c.srcB = alu_src_b;    c.aluOp = alu_op;
    c.immSel = imm_sel;   c.dRd = dmem_read;     c.dWr = dmem_write;
    c.rWr = reg_write;    c.wbSel = wb_sel;      c.epcWr = epc_write;
    c.causeWr = cause_write;
    return c;
  endfunction

  // Immediate format by major opcode.
  function automatic logic [2:0] immOf(input logic [6:0] op);
    case (op)
      7'h23:   return 3'd1;
      7'h63:   return 3'd2;
      7'h37:   return 3'd3;
      7'h6f:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic cyc_t mk(input state_t st, input logic [31:0] ins);
    cyc_t c;
    c = '0;
    c.st = st;
    c.immSel = immOf(ins[6:0]);
    return c;
  endfunction

  function automatic cyc_t resetCyc();
    cyc_t c;
    c = '0;
    c.st = RESET;
    return c;
  endfunction

  // Expected cycle-by-cycle outputs of one instruction, fetch included.
  function automatic void buildSeq(input logic [31:0] ins, input logic z, output cycQ_t q);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         kind;
    logic [2:0] aop;
    cyc_t       c;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    kind = 7;
    aop = 3'd0;
    q.delete();
    if (op == 7'h33) begin
      if (f7 == 7'h00 && f3 == 3'd0)      begin kind = 0; aop = 3'd1; end
      else if (f7 == 7'h00 && f3 == 3'd7) begin kind = 0; aop = 3'd3; end
      else if (f7 == 7'h00 && f3 == 3'd6) begin kind = 0; aop = 3'd4; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin kind = 0; aop = 3'd2; end
    end
    else if (op == 7'h13 && f3 == 3'd0) kind = 1;
    else if (op == 7'h03 && f3 == 3'd3) kind = 2;
    else if (op == 7'h23 && f3 == 3'd3) kind = 3;
    else if (op == 7'h63 && f3 <= 3'd1) kind = 4;
    else if (op == 7'h37)               kind = 5;
    else if (op == 7'h6f)               kind = 6;

    c = mk(FETCH, ins); c.imemRd = 1'b1;
    for (int i = 0; i < IW; i++) q.push_back(c);
    c = mk(FETCH_LD, ins); c.irLd = 1'b1; c.pcWr = 1'b1; c.srcB = 2'd1; c.aluOp = 3'd1;
    q.push_back(c);
    c = mk(DECODE, ins); c.aLd = 1'b1; c.bLd = 1'b1; c.aoLd = 1'b1;
    c.srcA = 2'd2; c.srcB = 2'd3; c.aluOp = 3'd1;
    q.push_back(c);
    case (kind)
      0, 1: begin
        c = mk(kind == 0 ? EX_R : EX_I, ins);
        c.srcA = 2'd1; c.srcB = (kind == 0) ? 2'd0 : 2'd2;
        c.aluOp = (kind == 0) ? aop : 3'd1; c.aoLd = 1'b1;
        q.push_back(c);
        c = mk(WB_ALU, ins); c.rWr = 1'b1; q.push_back(c);
      end
      2, 3: begin
        c = mk(MEM_ADDR, ins); c.srcA = 2'd1; c.srcB = 2'd2; c.aluOp = 3'd1; c.aoLd = 1'b1;
        q.push_back(c);
        for (int i = 0; i < DW; i++) begin
          c = mk(kind == 2 ? LD_REQ : SD_REQ, ins);
          c.dRd = (kind == 2);
          c.dWr = (kind == 3);
          c.mdrLd = (kind == 2) && (i == DW - 1);
          q.push_back(c);
        end
        if (kind == 2) begin
          c = mk(LD_WB, ins); c.rWr = 1'b1; c.wbSel = 2'd1; q.push_back(c);
        end
      end
      4: begin
        c = mk(BRANCH, ins); c.srcA = 2'd1; c.aluOp = 3'd2; c.pcSrc = 2'd1;
        c.pcWr = f3[0] ? ~z : z;
        q.push_back(c);
      end
      5: begin
        c = mk(LUI, ins); c.rWr = 1'b1; c.wbSel = 2'd3; q.push_back(c);
      end
      6: begin
        c = mk(JAL, ins); c.rWr = 1'b1; c.wbSel = 2'd2; c.pcWr = 1'b1; c.pcSrc = 2'd1;
        q.push_back(c);
      end
      default: begin
        c = mk(ILLEGAL, ins);
`ifdef CTRL_EXCEPTION_EN
        c.epcWr = 1'b1; c.causeWr = 1'b1; c.pcWr = 1'b1; c.pcSrc = 2'd2;
`endif
        q.push_back(c);
      end
    endcase
  endfunction

  // Random instruction: mostly legal encodings, plus near misses and noise.
  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0, 1: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0:       {r[31:25], r[14:12]} = {7'h00, 3'd0};
          1:       {r[31:25], r[14:12]} = {7'h20, 3'd0};
          2:       {r[31:25], r[14:12]} = {7'h00, 3'd7};
          default: {r[31:25], r[14:12]} = {7'h00, 3'd6};
        endcase
      end
      2: begin r[6:0] = 7'h13; r[14:12] = 3'd0; end
      3: begin r[6:0] = 7'h03; r[14:12] = 3'd3; end
      4: begin r[6:0] = 7'h23; r[14:12] = 3'd3; end
      5: begin r[6:0] = 7'h63; r[14:12] = 3'($urandom_range(0, 1)); end
      6: r[6:0] = 7'h37;
      7: r[6:0] = 7'h6f;
      8: begin
        case ($urandom_range(0, 4))
          0:       r[6:0] = 7'h33;
          1:       r[6:0] = 7'h13;
          2:       r[6:0] = 7'h03;
          3:       r[6:0] = 7'h23;
          default: r[6:0] = 7'h63;
        endcase
        if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      9: r = r;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Compare process: one expected entry per falling edge while work is queued.
  always @(negedge clk) begin : cmp
    cyc_t e;
    cyc_t a;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      a = sampleDut();
      check($sformatf("cycle t=%0t state=%0d", $time, e.st), 32'(a), 32'(e));
    end
  end

  // Drive one instruction from its FETCH cycle and wait for it to retire.
  task automatic runInstr(input logic [31:0] ins, input logic z);
    cycQ_t s;
    int    guard;
    instr    = ins;
    alu_zero = z;
    buildSeq(ins, z, s);
    foreach (s[i]) expQ.push_back(s[i]);
    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left want 0", expQ.size());
      expQ.delete();
    end
    #1;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.push_back(resetCyc());
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    cycQ_t s;
    int    n;
    reset    = 1'b1;
    instr    = 32'h0;
    alu_zero = 1'b0;
    #3;
    check("reset_outputs", 32'(sampleDut()), 32'(resetCyc()));

    // Pin the model with hand-derived values.
    buildSeq(32'h002081B3, 1'b0, s);
    check("pin_add_len", 32'(s.size()), 32'd5);
    check("pin_add_wb", 32'({s[4].st, s[4].rWr, s[4].wbSel}), 32'({5'd6, 1'b1, 2'd0}));
    n = 0;
    foreach (s[i]) n += int'(s[i].rWr);
    check("pin_add_rw_once", 32'(n), 32'd1);
    buildSeq(32'h0080B283, 1'b0, s);
    check("pin_ld_len", 32'(s.size()), 32'd8);
    n = 0;
    foreach (s[i]) n += int'(s[i].dRd);
    check("pin_ld_dread", 32'(n), 32'd3);
    check("pin_ld_mdr", 32'({s[4].mdrLd, s[5].mdrLd, s[6].mdrLd}), 32'd1);
    check("pin_ld_wb", 32'({s[7].rWr, s[7].wbSel}), 32'({1'b1, 2'd1}));
    buildSeq(32'h00208463, 1'b1, s);
    check("pin_beq_taken", 32'({s[3].pcWr, s[3].pcSrc}), 32'({1'b1, 2'd1}));
    buildSeq(32'h00209463, 1'b1, s);
    check("pin_bne_nottaken", 32'(s[3].pcWr), 32'd0);
    buildSeq(32'h010000EF, 1'b0, s);
    check("pin_jal", 32'({s[3].rWr, s[3].wbSel, s[3].pcWr, s[3].pcSrc}), 32'({1'b1, 2'd2, 1'b1, 2'd1}));
    buildSeq(32'h00000000, 1'b0, s);
    check("pin_ill_len", 32'(s.size()), 32'd4);
    buildSeq(32'h0010B023, 1'b0, s);
    check("pin_sd_len", 32'(s.size()), 32'd7);

    // Directed sequence, then randomized instructions.
    repeat (2) @(posedge clk);
    releaseReset();
    runInstr(32'h002081B3, 1'b0);
    runInstr(32'h0080B283, 1'b1);
    runInstr(32'h00208463, 1'b1);
    runInstr(32'h00208463, 1'b0);
    runInstr(32'h00209463, 1'b1);
    runInstr(32'h00209463, 1'b0);
    runInstr(32'h010000EF, 1'b0);
    runInstr(32'h00000000, 1'b0);
    runInstr(32'h40208133, 1'b0);
    runInstr(32'h0010B023, 1'b1);
    for (int i = 0; i < 300; i++) runInstr(randInstr(), 1'($urandom_range(0, 1)));

    // Reset asserted during the second LD_REQ wait cycle.
    instr    = 32'h0080B283;
    alu_zero = 1'b0;
    buildSeq(32'h0080B283, 1'b0, s);
    for (int i = 0; i < 6; i++) expQ.push_back(s[i]);
    repeat (6) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_dmem_read", 32'(dmem_read), 32'd0);
    check("midrst_state", 32'(state_o), 32'(RESET));
    check("midrst_all_zero", 32'(sampleDut()), 32'(resetCyc()));
    releaseReset();
    runInstr(32'h002081B3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
